// File: rtl/nios_system_sdram_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared encodings for the direct-call trace packer: trace codes, holding FSM
// states and packet geometry.
package nios_system_sdram_nios2_qsys_0_oci_dct_packer_pkg;

    typedef enum logic [1:0] {
        DCT_NONE = 2'b00,
        DCT_NT   = 2'b01,
        DCT_TK   = 2'b10,
        DCT_EXC  = 2'b11
    } dct_code_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

    localparam int CNT_W          = 4;
    localparam int DCT_DEPTH_DEF  = 15;
    localparam int PKT_W          = CNT_W + 2 * DCT_DEPTH_DEF;

endpackage

// File: rtl/nios_system_sdram_nios2_qsys_0_oci_dct_hold.sv
// One-entry valid/ready holding register for finished trace packets.
// The parent only asserts load_i while the entry is free or draining.
module nios_system_sdram_nios2_qsys_0_oci_dct_hold
    import nios_system_sdram_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
    parameter int DATA_W = PKT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    hold_state_e       state_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // A load while FULL is a drain-and-reload, so valid never drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (load_i) begin
                        state_q <= ST_FULL;
                        valid_q <= 1'b1;
                        data_q  <= data_i;
                    end
                end
                ST_FULL: begin
                    if (load_i) begin
                        data_q <= data_i;
                    end else if (ready_i) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/nios_system_sdram_nios2_qsys_0_oci_dct_packer.sv
// Accumulates 2-bit direct-call trace codes and hands complete or flushed
// packets to a one-entry holding register.
module nios_system_sdram_nios2_qsys_0_oci_dct_packer
    import nios_system_sdram_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
    parameter int DCT_DEPTH = DCT_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         trc_on,
    input  logic                         dct_valid,
    input  logic [1:0]                   dct_code,
    input  logic                         flush,
    input  logic                         pkt_ready,
    output logic [2*DCT_DEPTH-1:0]       dct_buffer,
    output logic [CNT_W-1:0]             dct_count,
    output logic                         pkt_valid,
    output logic [CNT_W+2*DCT_DEPTH-1:0] pkt_data,
    output logic                         dct_overflow
);

    localparam int BUF_W = 2 * DCT_DEPTH;

    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             trcOn_q;

    logic             codeOffered;
    logic             trcFall;
    logic             emitReq;
    logic             stall;
    logic             emit;
    logic [BUF_W-1:0] postBuffer;
    logic [CNT_W-1:0] postCount;

    // Post-update view includes this cycle's code so an emitted packet carries it.
    always_comb begin
        codeOffered = trc_on & dct_valid & (dct_code != DCT_NONE);
        trcFall     = trcOn_q & ~trc_on;
        postCount   = count_q;
        postBuffer  = buffer_q;
        if (codeOffered) begin
            postCount  = count_q + 1'b1;
            postBuffer = {buffer_q[BUF_W-3:0], dct_code};
        end
        emitReq = (codeOffered && (postCount == CNT_W'(DCT_DEPTH)))
                || ((flush || trcFall) && (postCount != '0))
                || (codeOffered && (dct_code == DCT_EXC));
        stall   = emitReq & pkt_valid & ~pkt_ready;
        emit    = emitReq & ~stall;

        count_d    = count_q;
        buffer_d   = buffer_q;
        overflow_d = overflow_q | (stall & codeOffered);
        if (!stall) begin
            if (emit) begin
                count_d  = '0;
                buffer_d = '0;
            end else if (codeOffered) begin
                count_d  = postCount;
                buffer_d = postBuffer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            trcOn_q    <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            trcOn_q    <= trc_on;
        end
    end

    nios_system_sdram_nios2_qsys_0_oci_dct_hold #(
        .DATA_W (CNT_W + BUF_W)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (emit),
        .data_i  ({postCount, postBuffer}),
        .ready_i (pkt_ready),
        .valid_o (pkt_valid),
        .data_o  (pkt_data)
    );

    assign dct_buffer   = buffer_q;
    assign dct_count    = count_q;
    assign dct_overflow = overflow_q;

endmodule

// File: tb/tb_nios_system_sdram_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the trace packer: directed code sequences push expected
// packets, a negedge monitor pops them on every valid/ready handshake.
module tb_nios_system_sdram_nios2_qsys_0_oci_dct_packer;
    import nios_system_sdram_nios2_qsys_0_oci_dct_packer_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             trc_on;
    logic             dct_valid;
    logic [1:0]       dct_code;
    logic             flush;
    logic             pkt_ready;
    logic [29:0]      dct_buffer;
    logic [3:0]       dct_count;
    logic             pkt_valid;
    logic [PKT_W-1:0] pkt_data;
    logic             dct_overflow;

    int               checks = 0;
    int               errors = 0;
    logic [PKT_W-1:0] expQ[$];

    always #5 clk = ~clk;

    nios_system_sdram_nios2_qsys_0_oci_dct_packer #(
        .DCT_DEPTH (15)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trc_on       (trc_on),
        .dct_valid    (dct_valid),
        .dct_code     (dct_code),
        .flush        (flush),
        .pkt_ready    (pkt_ready),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .dct_overflow (dct_overflow)
    );

    function automatic logic [PKT_W-1:0] mkPkt(input logic [3:0] c, input logic [29:0] b);
        return {c, b};
    endfunction

    task automatic checkOutput(input string name, input logic [PKT_W-1:0] actual,
                               input logic [PKT_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic f);
        dct_valid = v;
        dct_code  = c;
        flush     = f;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every handshake must match the oldest outstanding expected packet.
    always @(negedge clk) begin
        if (reset_n && pkt_valid && pkt_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected packet: got 0x%0h, expected none", pkt_data);
            end else begin
                checkOutput("packet", pkt_data, expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        trc_on    = 1'b0;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
        pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset buffer", dct_buffer, 0);
        checkOutput("reset count", dct_count, 0);
        checkOutput("reset pkt_valid", pkt_valid, 0);
        checkOutput("reset pkt_data", pkt_data, 0);
        checkOutput("reset overflow", dct_overflow, 0);
        reset_n = 1'b1;
        trc_on  = 1'b1;
        idleCycles(1);

        $display("[TB] full packet of taken codes");
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("count at 14", dct_count, 14);
        checkOutput("buffer at 14", dct_buffer, 30'h0AAAAAAA);
        expQ.push_back(mkPkt(4'd15, 30'h2AAAAAAA));
        applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("count after full", dct_count, 0);
        checkOutput("buffer after full", dct_buffer, 0);
        checkOutput("valid after full", pkt_valid, 1);
        idleCycles(2);
        checkOutput("valid after drain", pkt_valid, 0);

        $display("[TB] flush of partial packet");
        applyStimulus(1'b1, DCT_NT, 1'b0);
        applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("count before flush", dct_count, 2);
        checkOutput("buffer before flush", dct_buffer, 30'h6);
        expQ.push_back(mkPkt(4'd2, 30'h6));
        applyStimulus(1'b0, DCT_NONE, 1'b1);
        checkOutput("count after flush", dct_count, 0);
        idleCycles(2);
        applyStimulus(1'b0, DCT_NONE, 1'b1);
        checkOutput("empty flush valid", pkt_valid, 0);
        idleCycles(1);
        checkOutput("empty flush valid later", pkt_valid, 0);
        applyStimulus(1'b1, DCT_NONE, 1'b0);
        checkOutput("reserved code ignored", dct_count, 0);

        $display("[TB] exception code emits");
        applyStimulus(1'b1, DCT_NT, 1'b0);
        expQ.push_back(mkPkt(4'd2, 30'h7));
        applyStimulus(1'b1, DCT_EXC, 1'b0);
        checkOutput("count after exc", dct_count, 0);
        idleCycles(2);

        $display("[TB] stall with holding register full");
        pkt_ready = 1'b0;
        applyStimulus(1'b1, DCT_NT, 1'b0);
        expQ.push_back(mkPkt(4'd2, 30'h7));
        applyStimulus(1'b1, DCT_EXC, 1'b0);
        idleCycles(1);
        checkOutput("held valid", pkt_valid, 1);
        applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("overflow before stall", dct_overflow, 0);
        applyStimulus(1'b1, DCT_EXC, 1'b0);
        checkOutput("overflow on stall", dct_overflow, 1);
        checkOutput("count on stall", dct_count, 1);
        checkOutput("buffer on stall", dct_buffer, 30'h2);
        checkOutput("held data on stall", pkt_data, mkPkt(4'd2, 30'h7));
        checkOutput("held valid on stall", pkt_valid, 1);
        pkt_ready = 1'b1;
        idleCycles(2);
        checkOutput("valid after stall drain", pkt_valid, 0);
        expQ.push_back(mkPkt(4'd1, 30'h2));
        applyStimulus(1'b0, DCT_NONE, 1'b1);
        idleCycles(2);
        checkOutput("overflow sticky", dct_overflow, 1);

        $display("[TB] emit while draining");
        applyStimulus(1'b1, DCT_NT, 1'b0);
        expQ.push_back(mkPkt(4'd2, 30'h7));
        applyStimulus(1'b1, DCT_EXC, 1'b0);
        expQ.push_back(mkPkt(4'd1, 30'h3));
        applyStimulus(1'b1, DCT_EXC, 1'b0);
        checkOutput("valid no bubble", pkt_valid, 1);
        checkOutput("reloaded data", pkt_data, mkPkt(4'd1, 30'h3));
        idleCycles(2);

        $display("[TB] trace disable flushes");
        applyStimulus(1'b1, DCT_TK, 1'b0);
        expQ.push_back(mkPkt(4'd1, 30'h2));
        trc_on = 1'b0;
        applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("count after trc fall", dct_count, 0);
        checkOutput("buffer after trc fall", dct_buffer, 0);
        idleCycles(2);
        applyStimulus(1'b1, DCT_NT, 1'b0);
        checkOutput("code ignored trc off", dct_count, 0);
        trc_on = 1'b1;
        idleCycles(1);

        $display("[TB] reset mid-packet");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, DCT_NT, 1'b0);
        checkOutput("count at 7", dct_count, 7);
        checkOutput("buffer at 7", dct_buffer, 30'h1555);
        reset_n = 1'b0;
        idleCycles(1);
        checkOutput("mid reset buffer", dct_buffer, 0);
        checkOutput("mid reset count", dct_count, 0);
        checkOutput("mid reset pkt_valid", pkt_valid, 0);
        checkOutput("mid reset pkt_data", pkt_data, 0);
        checkOutput("mid reset overflow", dct_overflow, 0);
        reset_n = 1'b1;
        applyStimulus(1'b1, DCT_TK, 1'b0);
        checkOutput("count after reset", dct_count, 1);
        checkOutput("buffer after reset", dct_buffer, 30'h2);

        idleCycles(3);
        checkOutput("scoreboard drained", PKT_W'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_system_sdram_nios2_qsys_0_oci_dct_packer.md
NIOS_SYSTEM_SDRAM_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: nios_system_sdram_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL provide parameter DCT_DEPTH, default 15, meaning the maximum number of 2-bit direct-call trace codes per packet (buffer width = 2*DCT_DEPTH).
REQ-002 SHALL provide port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL provide port reset_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL provide port trc_on, input, 1, trace enable; codes are ignored while low.
REQ-005 SHALL provide port dct_valid, input, 1, a code is offered this cycle.
REQ-006 SHALL provide port dct_code, input, 2, code: 01 not-taken, 10 taken, 11 exception; 00 reserved, ignored.
REQ-007 SHALL provide port flush, input, 1, forces emission of a partial packet.
REQ-008 SHALL provide port pkt_ready, input, 1, downstream accepts the packet.
REQ-009 SHALL provide port dct_buffer, output, 30, live accumulation register.
REQ-010 SHALL provide port dct_count, output, 4, number of valid codes in dct_buffer (0..15).
REQ-011 SHALL provide port pkt_valid, output, 1, the holding register is occupied.
REQ-012 SHALL provide port pkt_data, output, 34, packet {count[3:0], buffer[29:0]}.
REQ-013 SHALL provide port dct_overflow, output, 1, sticky flag: a code was dropped.

Function
REQ-014 An accepted code (trc_on & dct_valid & code!=00 & not stalled) SHALL shift in at the LSBs: buffer <= {buffer[27:0], code}; count <= count+1.
REQ-015 The emit condition SHALL be (accepted code making count 15) OR (flush with post-update count > 0) OR (accepted code == 11).
REQ-016 On emit, the packet SHALL include the same-cycle code; the holding register SHALL load {new_count, new_buffer}; the accumulator SHALL clear to count 0, buffer 0 on the same edge.
REQ-017 A flush with count 0 and no accepted code SHALL emit nothing.
REQ-018 The holding register SHALL be one entry; pkt_valid SHALL rise the cycle after the emit and fall the cycle after pkt_valid & pkt_ready, unless reloaded.
REQ-019 Emit and drain in the same cycle SHALL reload the holding register with no bubble (pkt_valid stays 1).
REQ-020 The block SHALL be stalled when an emit is required while the holding register is full and is not draining; the triggering code SHALL then be dropped, the accumulator left unchanged, and dct_overflow set.
REQ-021 pkt_data SHALL be stable while pkt_valid & !pkt_ready.
REQ-022 Falling trc_on SHALL behave as an implicit flush in that cycle.
REQ-023 The FSM SHALL have states EMPTY (holding register free) and FULL (holding register occupied); EMPTY->FULL on emit; FULL->EMPTY on drain without emit; FULL->FULL on drain with emit, or on no drain.

Reset
REQ-024 With reset_n low at a clock edge: dct_buffer=0, dct_count=0, pkt_valid=0, pkt_data=0, dct_overflow=0, FSM=EMPTY.
REQ-025 Reset mid-packet SHALL discard both the accumulator and the holding register with no emission; the first code after release SHALL land at count 1.
REQ-026 dct_overflow SHALL clear only on reset.

Structure
REQ-027 A shared package SHALL hold the code encodings (NT, TK, EXC, NONE), the FSM state encoding and the packet width constant 34.
REQ-028 One sub-module SHALL be used: nios_system_sdram_nios2_qsys_0_oci_dct_hold, the one-entry valid/ready holding register; the accumulator stays in the parent.

Verification
REQ-029 With trc_on=1 and pkt_ready=1, 15 codes of 10 -> one packet, pkt_data=0x3_EAAAAAAA (count 15, buffer 0x2AAAAAAA); count returns to 0.
REQ-030 Apply codes 01,10,then flush -> pkt_data count=2, buffer=0x00000006; flush with count 0 -> no pkt_valid.
REQ-031 Apply codes 01,11 -> immediate packet, count=2, buffer=0x7.
REQ-032 Hold pkt_ready=0, fill two packets -> the second emit stalls, the code is dropped, dct_overflow=1, and the first packet's pkt_data is unchanged.
REQ-033 Emit with pkt_valid=1 and pkt_ready=1 in the same cycle -> pkt_valid stays 1 and the new data appears on the next cycle.
REQ-034 Pull reset_n low after 7 codes -> all outputs 0; next code -> dct_count=1.
